// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared types and constants for the data-memory arbiter:
//               sequencer state encoding and requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  // Sequencer states: arbitrate, drive memory for one cycle, acknowledge
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester identifiers (grant id encoding)
  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input grant selection. Round-robin by default using a
//               last-grant bit; fixed priority (port 0 wins ties) when the
//               DMEM_ARBITER_PRIORITY_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,    // a grant is being taken this cycle
  output logic grant_id,  // winning requester id
  output logic any_req
);

  assign any_req = req0 | req1;

`ifdef DMEM_ARBITER_PRIORITY_EN
  // Fixed priority: port 0 wins whenever it requests; no history kept
  always_comb begin
    grant_id = req0 ? REQ_CPU : REQ_LOADER;
  end
`else
  logic last_grant;

  // Tie goes to the port that did not win last; a single requester always wins
  always_comb begin
    grant_id = req0 ? REQ_CPU : REQ_LOADER;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end
  end

  // Remember the most recent winner; reset value makes port 0 win the first tie
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= REQ_LOADER;
    end else if (update && any_req) begin
      last_grant <= grant_id;
    end
  end
`endif

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port arbiter/sequencer in front of a single-port data
//               memory. Each granted command takes IDLE -> ACCESS -> RESP:
//               memory controls are driven in ACCESS only, the ack pulses in
//               RESP. Out-of-range addresses suppress the memory strobe and
//               return zero data with an error flag.
//               Optional macro: DMEM_ARBITER_PRIORITY_EN (fixed priority).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  output logic                  memWrite,
  output logic                  memRead,
  input  logic [DATA_WIDTH-1:0] memReadData
);

  // One extra bit so MEM_SIZE itself is representable for the compare
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

  state_t                state;
  state_t                state_next;
  logic                  grant_id;
  logic                  any_req;
  logic                  take_grant;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  cmd_id;
  logic                  cmd_we;
  logic                  cmd_err;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  assign take_grant = (state == IDLE);

  rr_arbiter2 u_arb (
    .clock    (clock),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .update   (take_grant),
    .grant_id (grant_id),
    .any_req  (any_req)
  );

  // Route the winning requester's command fields
  always_comb begin
    sel_we    = (grant_id == REQ_LOADER) ? we1    : we0;
    sel_addr  = (grant_id == REQ_LOADER) ? addr1  : addr0;
    sel_wdata = (grant_id == REQ_LOADER) ? wdata1 : wdata0;
  end

  // Sequencer state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and memory strobes; strobes only in ACCESS and never for a bad address
  always_comb begin
    state_next   = state;
    memWrite     = 1'b0;
    memRead      = 1'b0;
    memAddress   = cmd_addr;
    memWriteData = cmd_wdata;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        memWrite   = cmd_we & ~cmd_err;
        memRead    = ~cmd_we & ~cmd_err;
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the granted command and its range check when leaving IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_id    <= REQ_CPU;
      cmd_we    <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (take_grant && any_req) begin
      cmd_id    <= grant_id;
      cmd_we    <= sel_we;
      cmd_err   <= ({1'b0, sel_addr} >= MEM_LIMIT);
      cmd_addr  <= sel_addr;
      cmd_wdata <= sel_wdata;
    end
  end

  // Leaving ACCESS: raise the winner's ack/err for the RESP cycle and update its read data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      if (state == ACCESS) begin
        if (cmd_id == REQ_LOADER) begin
          ack1 <= 1'b1;
          err1 <= cmd_err;
          if (cmd_err) begin
            rdata1 <= '0;
          end else if (!cmd_we) begin
            rdata1 <= memReadData;
          end
        end else begin
          ack0 <= 1'b1;
          err0 <= cmd_err;
          if (cmd_err) begin
            rdata0 <= '0;
          end else if (!cmd_we) begin
            rdata0 <= memReadData;
          end
        end
      end
    end
  end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a transaction-level
//               reference model, a behavioural memory, directed scenarios and
//               randomized two-port traffic with occasional resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] memAddress, memWriteData, memReadData;
  logic        memWrite, memRead;

  wire [1:0] ack_v = {ack1, ack0};
  wire [1:0] err_v = {err1, err0};

  int n_chk  = 0;
  int n_pass = 0;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(256)) dut (
    .clock        (clock),
    .reset        (reset),
    .req0         (req_v[0]),
    .req1         (req_v[1]),
    .we0          (we_v[0]),
    .we1          (we_v[1]),
    .addr0        (addr_v[0]),
    .addr1        (addr_v[1]),
    .wdata0       (wdata_v[0]),
    .wdata1       (wdata_v[1]),
    .ack0         (ack0),
    .ack1         (ack1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .err0         (err0),
    .err1         (err1),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memWrite     (memWrite),
    .memRead      (memRead),
    .memReadData  (memReadData)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] init_val(input int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0101);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural data memory (combinational read)
  logic [31:0] dmem [256];
  always_comb begin
    memReadData = (memAddress < 32'd256) ? dmem[memAddress[7:0]] : 32'hBAD0_BAD0;
  end
  always @(posedge clock) begin
    if (memWrite && memAddress < 32'd256) dmem[memAddress[7:0]] <= memWriteData;
  end

  // ---------------- reference model (timestamped transactions) ----------------
  logic [31:0] mmem [256];
  int          e_cnt = 0;     // edges since last reset
  int          g_edge = -100; // edge of most recent grant
  bit          last = 1'b1;
  bit          m_id, m_we, m_err;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [31:0] exp_rd [2] = '{32'd0, 32'd0};

  initial begin
    forever begin
      bit acc, ak, w;
      @(posedge clock);
      #1;
      if (reset) begin
        e_cnt = 0; g_edge = -100; last = 1'b1;
        exp_rd[0] = 0; exp_rd[1] = 0;
        m_addr = 0; m_wdata = 0; m_id = 0; m_we = 0; m_err = 0;
      end else begin
        e_cnt++;
        if (e_cnt == g_edge + 1) begin
          if (m_err) exp_rd[m_id] = 0;
          else if (!m_we) exp_rd[m_id] = mmem[m_addr[7:0]];
          else mmem[m_addr[7:0]] = m_wdata;
        end
        if (e_cnt >= g_edge + 3 && req_v != 2'b00) begin
`ifdef DMEM_ARBITER_PRIORITY_EN
          w = req_v[0] ? 1'b0 : 1'b1;
`else
          if (req_v == 2'b11) w = ~last;
          else w = req_v[0] ? 1'b0 : 1'b1;
          last = w;
`endif
          g_edge = e_cnt; m_id = w; m_we = we_v[w];
          m_addr = addr_v[w]; m_wdata = wdata_v[w];
          m_err = (addr_v[w] >= 32'd256);
        end
      end
      acc = !reset && (e_cnt == g_edge);
      ak  = !reset && (e_cnt == g_edge + 1);
      chk("ack0", {31'd0, ack0}, {31'd0, ak && m_id == 1'b0});
      chk("ack1", {31'd0, ack1}, {31'd0, ak && m_id == 1'b1});
      chk("err0", {31'd0, err0}, {31'd0, ak && m_id == 1'b0 && m_err});
      chk("err1", {31'd0, err1}, {31'd0, ak && m_id == 1'b1 && m_err});
      chk("rdata0", rdata0, exp_rd[0]);
      chk("rdata1", rdata1, exp_rd[1]);
      chk("memWrite", {31'd0, memWrite}, {31'd0, acc && m_we && !m_err});
      chk("memRead", {31'd0, memRead}, {31'd0, acc && !m_we && !m_err});
      chk("memAddress", memAddress, m_addr);
      chk("memWriteData", memWriteData, m_wdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic txn(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output bit er, output logic [31:0] rd, output int wcnt);
    bit done = 0;
    @(posedge clock); #3;   // one quiet edge so the request meets IDLE
    req_v[p] = 1'b1; we_v[p] = w; addr_v[p] = a; wdata_v[p] = d;
    lat = 0; er = 0; rd = 0; wcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #3;
      lat++;
      if (memWrite) wcnt++;
      if (ack_v[p]) begin
        er = err_v[p];
        rd = (p == 1) ? rdata1 : rdata0;
        req_v[p] = 1'b0;
        done = 1;
        break;
      end
    end
    if (!done) chk("txn_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #3;
    reset = 1'b1; req_v = 2'b00;
    @(posedge clock); #3;
    reset = 1'b0;
  endtask

  task automatic rand_req(input int p);
    int r;
    req_v[p] = 1'b1;
    we_v[p] = 1'($urandom_range(0, 1));
    wdata_v[p] = $urandom;
    r = $urandom_range(0, 15);
    if (r < 2) addr_v[p] = 32'd256 + $urandom_range(0, 3);
    else if (r == 2) addr_v[p] = 32'hFFFF_FFF0 | $urandom_range(0, 15);
    else if (r == 3) addr_v[p] = 32'd255;
    else addr_v[p] = $urandom_range(0, 15);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, wcnt, k, n;
    bit er;
    logic [31:0] rd;
    int order [4];
    bit rst_pend;

    reset = 1'b1; req_v = 2'b00; we_v = 2'b00;
    addr_v[0] = 0; addr_v[1] = 0; wdata_v[0] = 0; wdata_v[1] = 0;
    for (int i = 0; i < 256; i++) begin
      dmem[i] = init_val(i);
      mmem[i] = init_val(i);
    end
    repeat (2) @(posedge clock);
    #3;
    chk("reset_memWrite", {31'd0, memWrite}, 32'd0);
    chk("reset_memAddress", memAddress, 32'd0);
    reset = 1'b0;

    // Write then read back on port 0
    txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, lat, er, rd, wcnt);
    chk("wr_latency", lat, 32'd2);
    chk("wr_memWrite_cycles", wcnt, 32'd1);
    chk("wr_err", {31'd0, er}, 32'd0);
    txn(0, 1'b0, 32'd5, 32'd0, lat, er, rd, wcnt);
    chk("rd_latency", lat, 32'd2);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_memWrite_cycles", wcnt, 32'd0);

    // Out-of-range write on port 1, then the last valid address
    txn(1, 1'b1, 32'd256, 32'hCAFE_F00D, lat, er, rd, wcnt);
    chk("oor_err", {31'd0, er}, 32'd1);
    chk("oor_rdata", rd, 32'd0);
    chk("oor_memWrite_cycles", wcnt, 32'd0);
    chk("oor_latency", lat, 32'd2);
    txn(1, 1'b0, 32'd255, 32'd0, lat, er, rd, wcnt);
    chk("edge255_err", {31'd0, er}, 32'd0);
    chk("edge255_rdata", rd, init_val(255));

    // Throughput: one held request yields acks every three cycles
    @(posedge clock); #3;
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'd5;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #3;
      if (ack0) begin
        chk("thru_ack_cycle", c, 2 + 3 * k);
        k++;
        if (k == 4) begin
          req_v[0] = 1'b0;
          break;
        end
      end
    end
    chk("thru_ack_count", k, 32'd4);

    // Tie handling from reset: both ports held
    pulse_reset();
    req_v = 2'b11; we_v = 2'b00; addr_v[0] = 32'd1; addr_v[1] = 32'd2;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(posedge clock); #3;
      if (ack0) begin order[n] = 0; n++; end
      else if (ack1) begin order[n] = 1; n++; end
    end
    req_v = 2'b00;
    chk("tie_count", n, 32'd4);
`ifdef DMEM_ARBITER_PRIORITY_EN
    for (int i = 0; i < 4; i++) chk("tie_order", order[i], 32'd0);
`else
    for (int i = 0; i < 4; i++) chk("tie_order", order[i], i % 2);
`endif

    // Reset during the ACCESS cycle of a write to address 7
    @(posedge clock); #3;
    @(posedge clock); #3;
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'd7; wdata_v[0] = 32'h1234_5678;
    @(posedge clock); #3;
    chk("midacc_memWrite_before", {31'd0, memWrite}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midacc_memWrite_after", {31'd0, memWrite}, 32'd0);
    req_v[0] = 1'b0;
    @(posedge clock); #3;
    chk("midacc_no_ack", {30'd0, ack_v}, 32'd0);
    reset = 1'b0;
    repeat (2) begin
      @(posedge clock); #3;
      chk("midacc_idle_ack", {30'd0, ack_v}, 32'd0);
    end
    txn(0, 1'b0, 32'd7, 32'd0, lat, er, rd, wcnt);
    chk("midacc_readback", rd, init_val(7));

    // Randomized two-port traffic with occasional resets
    rst_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #3;
      if (rst_pend) begin
        reset = 1'b0;
        rst_pend = 0;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        req_v = 2'b00;
        rst_pend = 1;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (req_v[p] && ack_v[p]) begin
            req_v[p] = 1'b0;
            if ($urandom_range(0, 1) == 1) rand_req(p);
          end else if (!req_v[p] && $urandom_range(0, 2) == 0) begin
            rand_req(p);
          end
        end
      end
    end
    reset = 1'b0;
    req_v = 2'b00;
    repeat (4) @(posedge clock);
    #3;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
